velocity_prcs: RTL and testbench

- Converts the ball's scalar speed and launch angle into packed Cartesian velocity components (vx, vy) for the ping-pong physics path.
- Pipelined CORDIC rotator. Sits between the angle/speed source (paddle-hit logic) and the ball-position integrator.
- Angle is measured from the +y axis: vx = v·sin(a), vy = v·cos(a).

---
 rtl/velocity_prcs.sv | 122 ++++++++++++
 tb/tb_velocity_prcs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_prcs.sv
// Pipelined CORDIC rotator: ball speed + launch angle (from +y) -> packed {vx, vy} in Q11.4.
// The quadrant is folded off at the input, rides along the pipe, and is unfolded before rounding.
module velocity_prcs #(
  parameter int ITER  = 16,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ball_velocity,
  input  logic [15:0] ball_angle,
  output logic [31:0] ball_velocity_modified
);

  localparam int XW = 16 + GUARD + 2;
  localparam int ZW = 24;
  localparam logic signed [31:0]   K_GAIN = 32'sd19898;
  localparam logic signed [XW-1:0] HALF   = XW'(1) <<< (GUARD - 1);
  localparam logic signed [XW-1:0] SAT_HI = XW'(32767);
  localparam logic signed [XW-1:0] SAT_LO = XW'(-32768);

  // z keeps 8 extra fraction bits: 90 degrees = 4096 << 8, so atan(1) = 524288.
  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 24'sd524288;
      1:       atan_lut = 24'sd309505;
      2:       atan_lut = 24'sd163534;
      3:       atan_lut = 24'sd83012;
      4:       atan_lut = 24'sd41667;
      5:       atan_lut = 24'sd20854;
      6:       atan_lut = 24'sd10430;
      7:       atan_lut = 24'sd5215;
      8:       atan_lut = 24'sd2608;
      9:       atan_lut = 24'sd1304;
      10:      atan_lut = 24'sd652;
      11:      atan_lut = 24'sd326;
      12:      atan_lut = 24'sd163;
      13:      atan_lut = 24'sd81;
      14:      atan_lut = 24'sd41;
      15:      atan_lut = 24'sd20;
      default: atan_lut = 24'sd0;
    endcase
  endfunction

  function automatic logic [15:0] round_sat(input logic signed [XW-1:0] val);
    logic signed [XW-1:0] shr;
    shr = (val + HALF) >>> GUARD;
    if (shr > SAT_HI)      round_sat = 16'h7FFF;
    else if (shr < SAT_LO) round_sat = 16'h8000;
    else                   round_sat = 16'(shr);
  endfunction

  logic signed [XW-1:0] x_d [0:ITER];
  logic signed [XW-1:0] x_q [0:ITER];
  logic signed [XW-1:0] y_d [0:ITER];
  logic signed [XW-1:0] y_q [0:ITER];
  logic signed [ZW-1:0] z_d [0:ITER];
  logic signed [ZW-1:0] z_q [0:ITER];
  logic [1:0]           q_d [0:ITER];
  logic [1:0]           q_q [0:ITER];
  logic signed [31:0]   prod_rnd;
  logic signed [XW-1:0] vx_pre;
  logic signed [XW-1:0] vy_pre;
  logic [31:0]          out_d;
  logic [31:0]          out_q;
  logic                 unused_angle_msbs;

  assign unused_angle_msbs = ^ball_angle[15:14];

  always_comb begin
    // Stage 0: pre-scale by the CORDIC gain, fold angle to its quadrant residual
    prod_rnd = 32'($signed(ball_velocity)) * K_GAIN + (32'sd1 <<< (14 - GUARD));
    x_d[0]   = XW'(prod_rnd >>> (15 - GUARD));
    y_d[0]   = '0;
    z_d[0]   = $signed({4'b0, ball_angle[11:0], 8'b0});
    q_d[0]   = ball_angle[13:12];
    // Stages 1..ITER: micro-rotations driving z toward zero
    for (int k = 1; k <= ITER; k++) begin
      if (z_q[k-1] < 0) begin
        x_d[k] = x_q[k-1] + (y_q[k-1] >>> (k - 1));
        y_d[k] = y_q[k-1] - (x_q[k-1] >>> (k - 1));
        z_d[k] = z_q[k-1] + atan_lut(k - 1);
      end else begin
        x_d[k] = x_q[k-1] - (y_q[k-1] >>> (k - 1));
        y_d[k] = y_q[k-1] + (x_q[k-1] >>> (k - 1));
        z_d[k] = z_q[k-1] - atan_lut(k - 1);
      end
      q_d[k] = q_q[k-1];
    end
  end

  always_comb begin
    // Output stage: x ~ v*cos r, y ~ v*sin r; unfold at full width before rounding
    vx_pre = y_q[ITER];
    vy_pre = x_q[ITER];
    case (q_q[ITER])
      2'd1: begin vx_pre = x_q[ITER];  vy_pre = -y_q[ITER]; end
      2'd2: begin vx_pre = -y_q[ITER]; vy_pre = -x_q[ITER]; end
      2'd3: begin vx_pre = -x_q[ITER]; vy_pre = y_q[ITER];  end
      default: ;
    endcase
    out_d = {round_sat(vx_pre), round_sat(vy_pre)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= '{default: '0};
      y_q   <= '{default: '0};
      z_q   <= '{default: '0};
      q_q   <= '{default: '0};
      out_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      q_q   <= q_d;
      out_q <= out_d;
    end
  end

  assign ball_velocity_modified = out_q;

endmodule

// File: tb/tb_velocity_prcs.sv
// Bench for velocity_prcs: real-valued sin/cos reference, scoreboard queue, 18-cycle latency.
module tb_velocity_prcs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ball_velocity;
  logic [15:0] ball_angle;
  logic [31:0] ball_velocity_modified;

  int checks = 0;
  int errors = 0;

  typedef struct {
    real ex;
    real ey;
  } exp_t;

  exp_t sb[$];

  velocity_prcs dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ball_velocity          (ball_velocity),
    .ball_angle             (ball_angle),
    .ball_velocity_modified (ball_velocity_modified)
  );

  always #5 clk = ~clk;

  function automatic real clamp16(input real r);
    if (r > 32767.0)  return 32767.0;
    if (r < -32768.0) return -32768.0;
    return r;
  endfunction

  // Angle from +y: vx = v*sin(a), vy = v*cos(a); 16384 codes per turn, top two bits ignored.
  function automatic exp_t model(input logic [15:0] v, input logic [15:0] a);
    exp_t e;
    real  th;
    th   = real'(a[13:0]) * 6.283185307179586 / 16384.0;
    e.ex = clamp16(real'($signed(v)) * $sin(th));
    e.ey = clamp16(real'($signed(v)) * $cos(th));
    return e;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ball_velocity_modified !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h, expected 00000000", c, ball_velocity_modified);
      end
    end
    rst_n = 1'b1;
    sb.push_back(model(ball_velocity, ball_angle));
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c < 18) begin
        checks++;
        if (ball_velocity_modified !== 32'h0) begin
          errors++;
          $display("FAIL reset_fill[%0d]: got %h, expected 00000000", c, ball_velocity_modified);
        end
      end else begin
        exp_t e;
        int   ox;
        int   oy;
        e  = sb.pop_front();
        ox = $signed(ball_velocity_modified[31:16]);
        oy = $signed(ball_velocity_modified[15:0]);
        checks += 2;
        if ($isunknown(ball_velocity_modified) || (real'(ox) - e.ex > 2.0) || (e.ex - real'(ox) > 2.0)) begin
          errors++;
          $display("FAIL reset_first vx: got %0d, expected %.3f +/-2", ox, e.ex);
        end
        if ($isunknown(ball_velocity_modified) || (real'(oy) - e.ey > 2.0) || (e.ey - real'(oy) > 2.0)) begin
          errors++;
          $display("FAIL reset_first vy: got %0d, expected %.3f +/-2", oy, e.ey);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] tv [14] = '{16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0,
                             16'h00F0, 16'h0000, 16'hFF10, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0] ta [14] = '{16'h0000, 16'h0555, 16'h0AAA, 16'h1000, 16'h2000, 16'h3000, 16'hF000,
                             16'hC555, 16'h1234, 16'h0555, 16'h0000, 16'h1000, 16'h2000, 16'h0800};
    for (int c = 0; c < 14 + 17; c++) begin
      if (c < 14) begin
        ball_velocity = tv[c];
        ball_angle    = ta[c];
        sb.push_back(model(tv[c], ta[c]));
      end else begin
        ball_velocity = '0;
        ball_angle    = '0;
      end
      @(posedge clk); #1;
      if (c >= 17) begin
        exp_t e;
        int   ox;
        int   oy;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL directed[%0d] scoreboard: got empty queue, expected a pending sample", c - 17);
        end else begin
          e  = sb.pop_front();
          ox = $signed(ball_velocity_modified[31:16]);
          oy = $signed(ball_velocity_modified[15:0]);
          checks += 2;
          if ($isunknown(ball_velocity_modified) || (real'(ox) - e.ex > 2.0) || (e.ex - real'(ox) > 2.0)) begin
            errors++;
            $display("FAIL directed[%0d] vx: got %0d, expected %.3f +/-2", c - 17, ox, e.ex);
          end
          if ($isunknown(ball_velocity_modified) || (real'(oy) - e.ey > 2.0) || (e.ey - real'(oy) > 2.0)) begin
            errors++;
            $display("FAIL directed[%0d] vy: got %0d, expected %.3f +/-2", c - 17, oy, e.ey);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 169;
    for (int c = 0; c < n + 17; c++) begin
      if (c < n) begin
        int rv;
        rv            = int'($urandom_range(16000)) - 8000;
        ball_velocity = 16'(rv);
        ball_angle    = 16'(c * 97) | (16'($urandom_range(3)) << 14);
        sb.push_back(model(ball_velocity, ball_angle));
      end else begin
        ball_velocity = '0;
        ball_angle    = '0;
      end
      @(posedge clk); #1;
      if (c >= 17) begin
        exp_t e;
        int   ox;
        int   oy;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sweep[%0d] scoreboard: got empty queue, expected a pending sample", c - 17);
        end else begin
          e  = sb.pop_front();
          ox = $signed(ball_velocity_modified[31:16]);
          oy = $signed(ball_velocity_modified[15:0]);
          checks += 2;
          if ($isunknown(ball_velocity_modified) || (real'(ox) - e.ex > 2.0) || (e.ex - real'(ox) > 2.0)) begin
            errors++;
            $display("FAIL sweep[%0d] vx: got %0d, expected %.3f +/-2", c - 17, ox, e.ex);
          end
          if ($isunknown(ball_velocity_modified) || (real'(oy) - e.ey > 2.0) || (e.ey - real'(oy) > 2.0)) begin
            errors++;
            $display("FAIL sweep[%0d] vy: got %0d, expected %.3f +/-2", c - 17, oy, e.ey);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 25; c++) begin
      ball_velocity = 16'($urandom_range(4000) + 100);
      ball_angle    = 16'($urandom_range(16383));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ball_velocity_modified !== 32'h0) begin
      errors++;
      $display("FAIL midreset_edge: got %h, expected 00000000", ball_velocity_modified);
    end
    rst_n         = 1'b1;
    ball_velocity = 16'h0F00;
    ball_angle    = 16'h1555;
    sb.push_back(model(ball_velocity, ball_angle));
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c < 18) begin
        checks++;
        if (ball_velocity_modified !== 32'h0) begin
          errors++;
          $display("FAIL midreset_flush[%0d]: got %h, expected 00000000", c, ball_velocity_modified);
        end
      end else begin
        exp_t e;
        int   ox;
        int   oy;
        e  = sb.pop_front();
        ox = $signed(ball_velocity_modified[31:16]);
        oy = $signed(ball_velocity_modified[15:0]);
        checks += 2;
        if ($isunknown(ball_velocity_modified) || (real'(ox) - e.ex > 2.0) || (e.ex - real'(ox) > 2.0)) begin
          errors++;
          $display("FAIL midreset_first vx: got %0d, expected %.3f +/-2", ox, e.ex);
        end
        if ($isunknown(ball_velocity_modified) || (real'(oy) - e.ey > 2.0) || (e.ey - real'(oy) > 2.0)) begin
          errors++;
          $display("FAIL midreset_first vy: got %0d, expected %.3f +/-2", oy, e.ey);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, expected summary before it");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst_n         = 1'b0;
    ball_velocity = 16'h00F0;
    ball_angle    = 16'h0555;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
